// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter: owner state
// encodings, requester ids and default bus widths.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 16;
  localparam int LOCK_MAX_DEF = 4;

  // Owner FSM encodings double as the value driven on the owner port.
  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_CPU_LOCK = 2'b01;
  localparam logic [1:0] ST_DBG_LOCK = 2'b10;

  // Requester ids used by the read tag and the last-winner pointer.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational grant selection for the RAM arbiter. A locked owner keeps
// the port until its lock count reaches LOCK_MAX while the other side waits.
// In IDLE a tie goes to the side opposite the last winner; the top ties
// last_winner to the dbg id when round-robin is not built, which turns this
// into fixed cpu priority without any change here.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF,
  parameter int CNT_W    = $clog2(LOCK_MAX + 1)
) (
  input  logic             cpu_req,
  input  logic             dbg_req,
  input  logic [1:0]       state,
  input  logic [CNT_W-1:0] lock_cnt,
  input  logic             last_winner,
  output logic             cpu_gnt,
  output logic             dbg_gnt
);

  logic at_limit;

  assign at_limit = (lock_cnt >= CNT_W'(LOCK_MAX));

  // Choose at most one winner from the current owner state and requests.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    case (state)
      ST_CPU_LOCK: begin
        if (cpu_req && !(at_limit && dbg_req)) cpu_gnt = 1'b1;
        else if (dbg_req)                      dbg_gnt = 1'b1;
      end
      ST_DBG_LOCK: begin
        if (dbg_req && !(at_limit && cpu_req)) dbg_gnt = 1'b1;
        else if (cpu_req)                      cpu_gnt = 1'b1;
      end
      default: begin
        if (cpu_req && dbg_req) begin
          if (last_winner == REQ_CPU) dbg_gnt = 1'b1;
          else                        cpu_gnt = 1'b1;
        end else begin
          cpu_gnt = cpu_req;
          dbg_gnt = dbg_req;
        end
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter sharing a single-port synchronous RAM between the
// CPU port and a debug/loader port. The winner is registered onto the RAM
// port; read data is routed back two edges after acceptance using a tag.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking in
// IDLE; otherwise the cpu always wins ties.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_lock,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_write,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        owner
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  lock_cnt, cnt_nxt;
  logic              last_winner;
  logic              any_gnt;
  logic              win_write;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              rd_pend, rd_tag;
  logic              rv_q, rv_tag;

  mem_arb_pick #(
    .LOCK_MAX (LOCK_MAX),
    .CNT_W    (CNT_W)
  ) u_pick (
    .cpu_req     (cpu_req),
    .dbg_req     (dbg_req),
    .state       (state),
    .lock_cnt    (lock_cnt),
    .last_winner (last_winner),
    .cpu_gnt     (cpu_gnt),
    .dbg_gnt     (dbg_gnt)
  );

  assign any_gnt   = cpu_gnt | dbg_gnt;
  assign win_write = dbg_gnt ? dbg_write : cpu_write;
  assign win_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
  assign win_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;

  // A locked accept enters or stays in that side's lock state; the counter
  // restarts at 1 on entry and saturates at LOCK_MAX; anything else is IDLE.
  always_comb begin
    state_nxt = ST_IDLE;
    cnt_nxt   = '0;
    if (cpu_gnt && cpu_lock) begin
      state_nxt = ST_CPU_LOCK;
      if (state != ST_CPU_LOCK)                cnt_nxt = CNT_W'(1);
      else if (lock_cnt == CNT_W'(LOCK_MAX))   cnt_nxt = lock_cnt;
      else                                     cnt_nxt = lock_cnt + CNT_W'(1);
    end else if (dbg_gnt && dbg_lock) begin
      state_nxt = ST_DBG_LOCK;
      if (state != ST_DBG_LOCK)                cnt_nxt = CNT_W'(1);
      else if (lock_cnt == CNT_W'(LOCK_MAX))   cnt_nxt = lock_cnt;
      else                                     cnt_nxt = lock_cnt + CNT_W'(1);
    end
  end

  // Owner state and lock counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= cnt_nxt;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember who won last so the next IDLE tie goes to the other side.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last_winner <= REQ_DBG;
    else if (cpu_gnt) last_winner <= REQ_CPU;
    else if (dbg_gnt) last_winner <= REQ_DBG;
  end
`else
  // Pinning the pointer to dbg makes every IDLE tie resolve to the cpu.
  assign last_winner = REQ_DBG;
`endif

  // Register the winning access onto the RAM port; the address and write
  // data hold when nothing is accepted, but the write strobe always drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_write <= 1'b0;
    end else begin
      mem_write <= any_gnt & win_write;
      if (any_gnt) begin
        mem_addr <= win_addr;
        mem_din  <= win_wdata;
      end
    end
  end

  // Two-stage read tag pipeline matching the RAM's one-cycle read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_tag  <= REQ_CPU;
      rv_q    <= 1'b0;
      rv_tag  <= REQ_CPU;
    end else begin
      rd_pend <= any_gnt & ~win_write;
      rd_tag  <= dbg_gnt ? REQ_DBG : REQ_CPU;
      rv_q    <= rd_pend;
      rv_tag  <= rd_tag;
    end
  end

  assign cpu_rvalid = rv_q & (rv_tag == REQ_CPU);
  assign dbg_rvalid = rv_q & (rv_tag == REQ_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_dout : '0;
  assign owner      = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: a table of per-cycle vectors with
// hand-computed expectations, plus short sequences for tie breaking and
// reset during an outstanding read. A behavioural RAM preloaded with
// mem[a] = a + 4 sits on the memory port.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_write, cpu_lock;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        dbg_req, dbg_write, dbg_lock;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic [7:0]  mem_addr;
  logic        mem_write;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic [1:0]  owner;

  logic [15:0] ram [256];

  int checks = 0;
  int errors = 0;

  // Fields: cpu req/write/addr/wdata/lock, dbg req/write/addr/wdata/lock,
  // then expected cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_rdata,
  // dbg_rdata, owner, mem_write, mem_addr, all sampled mid-cycle.
  typedef struct {
    int cr, cw, ca, cd, cl;
    int dr, dw, da, dd, dl;
    int cg, dg, crv, drv, crd, drd, own, mwr, maddr;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  mem_bus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_lock   (cpu_lock),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_write  (dbg_write),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_lock   (dbg_lock),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preload the RAM image
  initial begin
    for (int i = 0; i < 256; i++) ram[i] <= 16'(i + 4);
  end

  // Synchronous single-port RAM with one-cycle read latency
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic check_output(input string name, input int step,
                              input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got 0x%0h, want 0x%0h", name, step, act, 32'(exp));
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    cpu_req   = v.cr[0];
    cpu_write = v.cw[0];
    cpu_addr  = 8'(v.ca);
    cpu_wdata = 16'(v.cd);
    cpu_lock  = v.cl[0];
    dbg_req   = v.dr[0];
    dbg_write = v.dw[0];
    dbg_addr  = 8'(v.da);
    dbg_wdata = 16'(v.dd);
    dbg_lock  = v.dl[0];
  endtask

  task automatic check_row(input int r, input vec_t v);
    check_output("cpu_gnt",    r, 32'(cpu_gnt),    v.cg);
    check_output("dbg_gnt",    r, 32'(dbg_gnt),    v.dg);
    check_output("cpu_rvalid", r, 32'(cpu_rvalid), v.crv);
    check_output("dbg_rvalid", r, 32'(dbg_rvalid), v.drv);
    check_output("cpu_rdata",  r, 32'(cpu_rdata),  v.crd);
    check_output("dbg_rdata",  r, 32'(dbg_rdata),  v.drd);
    check_output("owner",      r, 32'(owner),      v.own);
    check_output("mem_write",  r, 32'(mem_write),  v.mwr);
    check_output("mem_addr",   r, 32'(mem_addr),   v.maddr);
  endtask

  task automatic go_idle();
    vec_t z;
    z = '{default: 0};
    apply_stimulus(z);
  endtask

  initial begin
    logic exp_c;

    //          cr cw ca    cd      cl  dr dw da    dd      dl  cg dg crv drv crd      drd      own mwr maddr
    vecs[0]  = '{0, 0, 'h00, 'h0000, 0,  0, 0, 'h00, 'h0000, 0,  0, 0, 0,  0,  'h0000,  'h0000,  0,  0,  'h00};
    vecs[1]  = '{1, 0, 'h03, 'h0000, 0,  0, 0, 'h00, 'h0000, 0,  1, 0, 0,  0,  'h0000,  'h0000,  0,  0,  'h00};
    vecs[2]  = '{0, 0, 'h00, 'h0000, 0,  1, 1, 'h10, 'h0003, 0,  0, 1, 0,  0,  'h0000,  'h0000,  0,  0,  'h03};
    vecs[3]  = '{1, 0, 'h10, 'h0000, 0,  0, 0, 'h00, 'h0000, 0,  1, 0, 1,  0,  'h0007,  'h0000,  0,  1,  'h10};
    vecs[4]  = '{0, 0, 'h00, 'h0000, 0,  0, 0, 'h00, 'h0000, 0,  0, 0, 0,  0,  'h0000,  'h0000,  0,  0,  'h10};
    vecs[5]  = '{0, 0, 'h00, 'h0000, 0,  0, 0, 'h00, 'h0000, 0,  0, 0, 1,  0,  'h0003,  'h0000,  0,  0,  'h10};
    vecs[6]  = '{0, 0, 'h00, 'h0000, 0,  1, 0, 'h20, 'h0000, 0,  0, 1, 0,  0,  'h0000,  'h0000,  0,  0,  'h10};
    vecs[7]  = '{0, 0, 'h00, 'h0000, 0,  0, 0, 'h00, 'h0000, 0,  0, 0, 0,  0,  'h0000,  'h0000,  0,  0,  'h20};
    vecs[8]  = '{0, 0, 'h00, 'h0000, 0,  0, 0, 'h00, 'h0000, 0,  0, 0, 0,  1,  'h0000,  'h0024,  0,  0,  'h20};
    vecs[9]  = '{1, 0, 'h05, 'h0000, 1,  1, 0, 'h30, 'h0000, 0,  1, 0, 0,  0,  'h0000,  'h0000,  0,  0,  'h20};
    vecs[10] = '{1, 0, 'h05, 'h0000, 1,  1, 0, 'h30, 'h0000, 0,  1, 0, 0,  0,  'h0000,  'h0000,  1,  0,  'h05};
    vecs[11] = '{1, 0, 'h05, 'h0000, 1,  1, 0, 'h30, 'h0000, 0,  1, 0, 1,  0,  'h0009,  'h0000,  1,  0,  'h05};
    vecs[12] = '{1, 0, 'h05, 'h0000, 1,  1, 0, 'h30, 'h0000, 0,  1, 0, 1,  0,  'h0009,  'h0000,  1,  0,  'h05};
    vecs[13] = '{1, 0, 'h05, 'h0000, 1,  1, 0, 'h30, 'h0000, 0,  0, 1, 1,  0,  'h0009,  'h0000,  1,  0,  'h05};
    vecs[14] = '{1, 0, 'h05, 'h0000, 1,  0, 0, 'h00, 'h0000, 0,  1, 0, 1,  0,  'h0009,  'h0000,  0,  0,  'h30};
    vecs[15] = '{1, 0, 'h05, 'h0000, 1,  0, 0, 'h00, 'h0000, 0,  1, 0, 0,  1,  'h0000,  'h0034,  1,  0,  'h05};
    vecs[16] = '{0, 0, 'h00, 'h0000, 0,  0, 0, 'h00, 'h0000, 0,  0, 0, 1,  0,  'h0009,  'h0000,  1,  0,  'h05};
    vecs[17] = '{0, 0, 'h00, 'h0000, 0,  0, 0, 'h00, 'h0000, 0,  0, 0, 1,  0,  'h0009,  'h0000,  0,  0,  'h05};
    vecs[18] = '{0, 0, 'h00, 'h0000, 0,  0, 0, 'h00, 'h0000, 0,  0, 0, 0,  0,  'h0000,  'h0000,  0,  0,  'h05};
    vecs[19] = '{1, 1, 'h07, 'hBEEF, 0,  0, 0, 'h00, 'h0000, 0,  1, 0, 0,  0,  'h0000,  'h0000,  0,  0,  'h05};
    vecs[20] = '{1, 0, 'h07, 'h0000, 0,  0, 0, 'h00, 'h0000, 0,  1, 0, 0,  0,  'h0000,  'h0000,  0,  1,  'h07};
    vecs[21] = '{0, 0, 'h00, 'h0000, 0,  0, 0, 'h00, 'h0000, 0,  0, 0, 0,  0,  'h0000,  'h0000,  0,  0,  'h07};
    vecs[22] = '{0, 0, 'h00, 'h0000, 0,  0, 0, 'h00, 'h0000, 0,  0, 0, 1,  0,  'hBEEF,  'h0000,  0,  0,  'h07};

    reset = 1'b1;
    go_idle();

    // Reset values
    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("rst_mem_addr",   0, 32'(mem_addr),   0);
    check_output("rst_mem_write",  0, 32'(mem_write),  0);
    check_output("rst_mem_din",    0, 32'(mem_din),    0);
    check_output("rst_cpu_rvalid", 0, 32'(cpu_rvalid), 0);
    check_output("rst_dbg_rvalid", 0, 32'(dbg_rvalid), 0);
    check_output("rst_owner",      0, 32'(owner),      0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven cycles
    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      apply_stimulus(vecs[r]);
      #1;
      check_row(r, vecs[r]);
    end
    @(negedge clk);
    go_idle();

    // Both sides requesting reads from a fresh reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_req  = 1'b1; cpu_write = 1'b0; cpu_addr = 8'(i);        cpu_lock = 1'b0;
      dbg_req  = 1'b1; dbg_write = 1'b0; dbg_addr = 8'(i + 'h40); dbg_lock = 1'b0;
      #1;
`ifdef MEM_ARB_RR_EN
      exp_c = (i % 2 == 0);
`else
      exp_c = 1'b1;
`endif
      check_output("tie_cpu_gnt", 100 + i, 32'(cpu_gnt), int'(exp_c));
      check_output("tie_dbg_gnt", 100 + i, 32'(dbg_gnt), int'(!exp_c));
    end
    @(negedge clk);
    go_idle();
    repeat (3) @(negedge clk);

    // Reset one cycle after a locked read accept drops the read
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h03; cpu_lock = 1'b1;
    #1;
    check_output("rr_cpu_gnt", 200, 32'(cpu_gnt), 1);
    @(negedge clk);
    go_idle();
    #1;
    check_output("rr_owner_locked", 201, 32'(owner), 1);
    reset = 1'b1;
    #1;
    check_output("rr_owner_rst", 202, 32'(owner),     0);
    check_output("rr_maddr_rst", 202, 32'(mem_addr),  0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_output("rr_cpu_rvalid", 210 + i, 32'(cpu_rvalid), 0);
      check_output("rr_dbg_rvalid", 210 + i, 32'(dbg_rvalid), 0);
      check_output("rr_mem_write",  210 + i, 32'(mem_write),  0);
      check_output("rr_owner",      210 + i, 32'(owner),      0);
      check_output("rr_gnt",        210 + i, 32'({cpu_gnt, dbg_gnt}), 0);
    end

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
